// File: rtl/ahb_req_master.sv
// AHB (AMBA 2) single-transfer master: turns a valid/ready request stream into
// pipelined NONSEQ/SINGLE transfers and returns one in-order response per request.
//
// state   | meaning
// DP_IDLE | no transfer in the data phase
// DP_WAIT | data phase in progress, waiting for HREADY
// RESP2   | second cycle of an ERROR/RETRY/SPLIT response
module ahb_req_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [2:0]               req_size,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_error,
    output logic                     HBUSREQ,
    input  logic                     HGRANT,
    output logic [1:0]               HTRANS,
    output logic [ADDRESS_WIDTH-1:0] HADDR,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [2:0]               HBURST,
    output logic [3:0]               HPROT,
    output logic [DATA_WIDTH-1:0]    HWDATA,
    input  logic [DATA_WIDTH-1:0]    HRDATA,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_WAIT,
        RESP2
    } dp_state_t;

    typedef struct packed {
        logic                     write;
        logic [2:0]               size;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } xfer_t;

    dp_state_t dp_state, dp_state_nxt;

    xfer_t ap, dp, hold, req_xfer;
    logic  ap_valid, hold_valid;
    logic  cancel;
    logic  dp_replay;
    logic  owner;

    logic  nonseq;
    logic  ap_advance;
    logic  req_accept;

    logic  dp_load;
    logic  dp_complete;
    logic  dp_err_done;
    logic  replay;
    logic  cancel_set;
    logic  cancel_clr;

    assign req_xfer = '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata};

    assign nonseq     = ap_valid & ~cancel & owner;
    assign ap_advance = nonseq & HREADY;
    assign req_ready  = HRESETn & ~hold_valid & ~cancel & (~ap_valid | ap_advance);
    assign req_accept = req_valid & req_ready;

    assign HTRANS  = nonseq ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR   = ap.addr;
    assign HWRITE  = ap.write;
    assign HSIZE   = ap.size;
    assign HWDATA  = dp.wdata;
    assign HBURST  = 3'b000;
    assign HPROT   = 4'b0011;
    assign HBUSREQ = ap_valid | hold_valid;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_state <= DP_IDLE;
        end else begin
            dp_state <= dp_state_nxt;
        end
    end

    always_comb begin
        dp_state_nxt = dp_state;
        dp_load      = 1'b0;
        dp_complete  = 1'b0;
        dp_err_done  = 1'b0;
        replay       = 1'b0;
        cancel_set   = 1'b0;
        cancel_clr   = 1'b0;
        case (dp_state)
            DP_IDLE: begin
                if (ap_advance) begin
                    dp_load      = 1'b1;
                    dp_state_nxt = DP_WAIT;
                end
            end
            DP_WAIT: begin
                if (HREADY) begin
                    dp_complete = 1'b1;
                    if (ap_advance) begin
                        dp_load = 1'b1;
                    end else begin
                        dp_state_nxt = DP_IDLE;
                    end
                end else if (HRESP != RESP_OKAY) begin
                    // First cycle of a two-cycle response: stop the address phase now.
                    cancel_set   = 1'b1;
                    dp_state_nxt = RESP2;
                end
            end
            RESP2: begin
                if (HREADY) begin
                    cancel_clr   = 1'b1;
                    dp_state_nxt = DP_IDLE;
                    if (dp_replay) begin
                        replay = 1'b1;
                    end else begin
                        dp_err_done = 1'b1;
                    end
                end
            end
            default: dp_state_nxt = DP_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap         <= '0;
            ap_valid   <= 1'b0;
            dp         <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            cancel     <= 1'b0;
            dp_replay  <= 1'b0;
            owner      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            if (dp_complete) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= dp.write ? '0 : HRDATA;
            end
            if (dp_err_done) begin
                rsp_valid <= 1'b1;
                rsp_error <= 1'b1;
            end

            if (HREADY) begin
                owner <= HGRANT;
            end

            if (cancel_set) begin
                cancel    <= 1'b1;
                dp_replay <= HRESP[1];
            end else if (cancel_clr) begin
                cancel <= 1'b0;
            end

            if (dp_load) begin
                dp <= ap;
            end

            // A replayed transfer jumps ahead of the parked one; HOLD refills AP
            // once the replay has left the address phase.
            if (replay) begin
                ap       <= dp;
                ap_valid <= 1'b1;
                if (ap_valid) begin
                    hold       <= ap;
                    hold_valid <= 1'b1;
                end
            end else if (ap_advance) begin
                if (hold_valid) begin
                    ap         <= hold;
                    hold_valid <= 1'b0;
                end else if (req_accept) begin
                    ap <= req_xfer;
                end else begin
                    ap_valid <= 1'b0;
                end
            end else if (req_accept) begin
                ap       <= req_xfer;
                ap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_req_master.sv
// Bench for ahb_req_master: a scripted AHB slave plus an in-order request
// scoreboard with a reference memory, checked every cycle at mid-period.
module tb_ahb_req_master;

    logic        HCLK;
    logic        HRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        HBUSREQ;
    logic        HGRANT;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    ahb_req_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HBUSREQ(HBUSREQ), .HGRANT(HGRANT), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } want_t;

    req_t        reqs[$];
    want_t       want_q[$];
    logic [31:0] slvmem[logic [31:0]];
    logic [31:0] refmem[logic [31:0]];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issue_ptr = 0;
    int rsp_cnt = 0;

    int          slv_waits = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = '0;
    logic [31:0] retry_addr = '0;
    int          retry_cnt = 0;

    bit dph_active = 0;
    int dph_idx = 0;
    int dph_cnt = 0;
    int dph_kind = 0;

    bit          p_adv = 0;
    int          p_adv_idx = 0;
    bit          p_hready = 1;
    bit          p_rst = 1;
    bit          p_first_err = 0;
    logic [1:0]  p_htrans = '0;
    logic [31:0] p_haddr = '0;

    bit          acc_now = 0;
    bit          chk_lat = 0;
    bit          chk_wait = 0;
    logic [7:0]  err_log = '0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        if (slvmem.exists(a)) return slvmem[a];
        return a ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (refmem.exists(a)) return refmem[a];
        return a ^ 32'h5A5A0000;
    endfunction

    // Slave drive at each negedge, then sample and compare at negedge+2.
    initial begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (p_rst) begin
                dph_active = 0;
            end else begin
                if (dph_active && p_hready) dph_active = 0;
                else if (dph_active) dph_cnt++;
                if (p_adv) begin
                    dph_active = 1;
                    dph_idx    = p_adv_idx;
                    dph_cnt    = 0;
                    dph_kind   = 0;
                    if (err_en && reqs[dph_idx].a == err_addr) begin
                        dph_kind = 1;
                    end else if (retry_cnt > 0 && reqs[dph_idx].a == retry_addr) begin
                        dph_kind = 2;
                        retry_cnt--;
                    end
                end
            end
            HREADY = 1'b1;
            HRESP  = 2'b00;
            HRDATA = '0;
            if (dph_active) begin
                if (dph_cnt < slv_waits) begin
                    HREADY = 1'b0;
                end else if (dph_kind == 0) begin
                    if (!reqs[dph_idx].w) HRDATA = slv_rd(reqs[dph_idx].a);
                end else begin
                    HREADY = (dph_cnt != slv_waits);
                    HRESP  = (dph_kind == 1) ? 2'b01 : 2'b10;
                end
            end

            #2;
            cyc++;
            check("hprot", HPROT, 4'b0011);
            check("hburst", HBURST, 3'b000);
            check("htrans_legal", (HTRANS == 2'b00 || HTRANS == 2'b10), 1'b1);
            if (p_first_err && HRESETn) check("idle_after_resp1", HTRANS, 2'b00);
            if (chk_wait && HRESETn && !p_hready && p_htrans == 2'b10)
                check("haddr_stable_wait", HADDR, p_haddr);
            if (chk_wait && req_valid && !HREADY) check("ready_low_wait", req_ready, 1'b0);

            acc_now = req_valid && req_ready;

            if (rsp_valid) begin
                rsp_cnt++;
                last_rdata = rsp_rdata;
                err_log    = {err_log[6:0], rsp_error};
                if (want_q.size() == 0) begin
                    check("rsp_spurious", rsp_valid, 1'b0);
                end else begin
                    want_t w;
                    w = want_q.pop_front();
                    check("rsp_error", rsp_error, w.err);
                    if (!w.err) check("rsp_rdata", rsp_rdata, w.rd);
                    if (chk_lat) check("rsp_latency", cyc - w.cyc, 3);
                end
            end

            if (dph_active && HREADY && HRESETn) begin
                if (dph_kind == 0 && reqs[dph_idx].w) begin
                    check("hwdata", HWDATA, reqs[dph_idx].d);
                    slvmem[reqs[dph_idx].a] = HWDATA;
                end
                if (dph_kind == 2) issue_ptr--;
            end

            p_adv = HRESETn && HTRANS == 2'b10 && HREADY;
            if (p_adv) begin
                if (issue_ptr < reqs.size()) begin
                    check("haddr", HADDR, reqs[issue_ptr].a);
                    check("hwrite", HWRITE, reqs[issue_ptr].w);
                    check("hsize", HSIZE, reqs[issue_ptr].s);
                    p_adv_idx = issue_ptr;
                    issue_ptr++;
                end else begin
                    check("addr_phase_unexpected", p_adv, 1'b0);
                    p_adv = 0;
                end
            end

            if (HRESETn && acc_now) begin
                req_t  r;
                want_t w;
                r.w = req_write; r.a = req_addr; r.s = req_size; r.d = req_wdata;
                reqs.push_back(r);
                w.err = err_en && (req_addr == err_addr);
                w.cyc = cyc;
                w.rd  = '0;
                if (req_write) begin
                    if (!w.err) refmem[req_addr] = req_wdata;
                end else begin
                    w.rd = ref_rd(req_addr);
                end
                want_q.push_back(w);
            end

            if (!HRESETn) begin
                want_q.delete();
                issue_ptr = reqs.size();
                refmem    = slvmem;
                p_adv     = 0;
            end
            p_rst       = !HRESETn;
            p_hready    = HREADY;
            p_first_err = HRESETn && !HREADY && HRESP != 2'b00;
            p_htrans    = HTRANS;
            p_haddr     = HADDR;
        end
    end

    // Called and returns at a negedge.
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bit got;
        got = 0;
        req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (acc_now) begin
                got = 1;
                break;
            end
            @(negedge HCLK);
        end
        if (!got) check("accept_timeout", got, 1'b1);
        @(negedge HCLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            #3;
            if (want_q.size() == 0 && !dph_active) begin
                done = 1;
                break;
            end
            @(negedge HCLK);
        end
        if (!done) check("drain_timeout", done, 1'b1);
        @(negedge HCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, HTRANS, 2'b00);
        check({tag, "_haddr"}, HADDR, 32'h0);
        check({tag, "_hwrite"}, HWRITE, 1'b0);
        check({tag, "_hsize"}, HSIZE, 3'b000);
        check({tag, "_hwdata"}, HWDATA, 32'h0);
        check({tag, "_hbusreq"}, HBUSREQ, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_error"}, rsp_error, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    initial begin
        int base_cnt;
        HRESETn = 1'b0; HGRANT = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (2) @(negedge HCLK);
        #3;
        check_reset_outputs("rst");
        check("rst_req_ready", req_ready, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Write then read, zero wait, 3-cycle latency each
        chk_lat = 1;
        send(1'b1, 32'h1000, 3'd2, 32'hDEADBEEF);
        send(1'b0, 32'h1000, 3'd2, 32'h0);
        wait_idle();
        chk_lat = 0;
        check("t1_read_value", last_rdata, 32'hDEADBEEF);

        // Eight back-to-back writes with two wait states, then read them back
        base_cnt  = rsp_cnt;
        slv_waits = 2;
        chk_wait  = 1;
        for (int i = 0; i < 8; i++) send(1'b1, 32'h2000 + 32'(4 * i), 3'd2, 32'hA5000000 | 32'(i));
        wait_idle();
        chk_wait  = 0;
        slv_waits = 0;
        for (int i = 0; i < 8; i++) send(1'b0, 32'h2000 + 32'(4 * i), 3'd2, 32'h0);
        wait_idle();
        check("t2_rsp_count", rsp_cnt - base_cnt, 16);
        check("t2_last_read", last_rdata, 32'hA5000007);

        // ERROR on the middle of three pipelined reads
        err_en = 1; err_addr = 32'h3004; err_log = '0;
        send(1'b0, 32'h3000, 3'd2, 32'h0);
        send(1'b0, 32'h3004, 3'd2, 32'h0);
        send(1'b0, 32'h3008, 3'd2, 32'h0);
        wait_idle();
        err_en = 0;
        check("t3_err_seq", err_log[2:0], 3'b010);
        check("t3_last_read", last_rdata, 32'h5A5A3008);

        // RETRY on a write while a read waits in the address phase
        retry_addr = 32'h4000; retry_cnt = 1; err_log = '0;
        send(1'b1, 32'h4000, 3'd2, 32'h12345678);
        send(1'b0, 32'h4000, 3'd2, 32'h0);
        wait_idle();
        check("t4_retry_used", retry_cnt, 0);
        check("t4_err_seq", err_log[1:0], 2'b00);
        check("t4_read_value", last_rdata, 32'h12345678);

        // Grant withheld for five cycles
        HGRANT = 1'b0;
        repeat (2) @(negedge HCLK);
        send(1'b0, 32'h5000, 3'd1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #3;
            check("t5_hbusreq", HBUSREQ, 1'b1);
            check("t5_htrans_idle", HTRANS, 2'b00);
            @(negedge HCLK);
        end
        HGRANT = 1'b1;
        #3;
        check("t5_idle_grant_cycle", HTRANS, 2'b00);
        @(negedge HCLK);
        #3;
        check("t5_nonseq_after_grant", HTRANS, 2'b10);
        @(negedge HCLK);
        wait_idle();
        check("t5_read_value", last_rdata, 32'h5A5A5000);

        // Reset during a wait-state data phase
        slv_waits = 3;
        send(1'b1, 32'h6000, 3'd2, 32'hCAFEF00D);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #3;
        check("t6_rst_req_ready", req_ready, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #3;
        check_reset_outputs("t6");
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            #3;
            check("t6_no_rsp", rsp_valid, 1'b0);
        end
        @(negedge HCLK);
        slv_waits = 0;
        send(1'b0, 32'h6000, 3'd2, 32'h0);
        wait_idle();
        check("t6_read_after_reset", last_rdata, 32'h5A5A6000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
